// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory for the load/store stage: byte/half/word accesses,
// configurable wait states and endianness, valid/ready request and response channels.
module data_mem_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int LATENCY    = 1,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, next_state;

    logic [7:0]  mem [DEPTH];

    logic        ready_en;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic        lat_sign_ext;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        acc_we;
    logic        acc_sign_ext;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_bad;
    int          acc_bytes;
    logic [ADDR_W-1:0] lane_addr [4];
    logic [31:0] raw_rdata;
    logic [31:0] load_value;
    logic        accept;
    logic        commit;

    // In IDLE the live request is used, so a zero-latency access can commit on its accept edge.
    always_comb begin
        if (state == IDLE) begin
            acc_we       = req_we;
            acc_sign_ext = req_sign_ext;
            acc_size     = req_size;
            acc_addr     = req_addr;
            acc_wdata    = req_wdata;
        end else begin
            acc_we       = lat_we;
            acc_sign_ext = lat_sign_ext;
            acc_size     = lat_size;
            acc_addr     = lat_addr;
            acc_wdata    = lat_wdata;
        end
    end

    always_comb begin
        acc_bad = (acc_size == 2'd3) ||
                  (acc_size == 2'd1 && acc_addr[0]) ||
                  (acc_size == 2'd2 && acc_addr[1:0] != 2'b00) ||
                  ((acc_addr >> ADDR_W) != 32'd0);
        case (acc_size)
            2'd0:    acc_bytes = 1;
            2'd1:    acc_bytes = 2;
            default: acc_bytes = 4;
        endcase
    end

    // Lane i carries value byte i (lane 0 = LSB); big-endian places the MSB at the lowest address.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (BIG_ENDIAN)
                lane_addr[i] = acc_addr[ADDR_W-1:0] + ADDR_W'(acc_bytes - 1 - i);
            else
                lane_addr[i] = acc_addr[ADDR_W-1:0] + ADDR_W'(i);
        end
    end

    always_comb begin
        raw_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i < acc_bytes)
                raw_rdata[8*i +: 8] = mem[lane_addr[i]];
        end
    end

    always_comb begin
        case (acc_size)
            2'd0:    load_value = acc_sign_ext ? {{24{raw_rdata[7]}}, raw_rdata[7:0]}
                                               : {24'd0, raw_rdata[7:0]};
            2'd1:    load_value = acc_sign_ext ? {{16{raw_rdata[15]}}, raw_rdata[15:0]}
                                               : {16'd0, raw_rdata[15:0]};
            default: load_value = raw_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ready_en;
                if (req_valid && ready_en) begin
                    accept = 1'b1;
                    if (acc_bad) begin
                        next_state = RESP;
                    end else if (LATENCY == 0) begin
                        commit     = 1'b1;
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ready_en keeps req_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en     <= 1'b0;
            wait_cnt     <= 4'd0;
            lat_we       <= 1'b0;
            lat_sign_ext <= 1'b0;
            lat_size     <= 2'd0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                lat_we       <= req_we;
                lat_sign_ext <= req_sign_ext;
                lat_size     <= req_size;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                wait_cnt     <= WAIT_LOAD;
                err_q        <= acc_bad;
                rdata_q      <= 32'd0;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit)
                rdata_q <= acc_we ? 32'd0 : load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i < acc_bytes)
                    mem[lane_addr[i]] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (LE/lat1, BE/lat4, LE/lat0) driven by a vector
// table, hand-written backpressure/reset sequences and random traffic against a byte-array model.
module tb_data_mem_ctrl;

    logic        clk;
    logic [2:0]  rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [2:0]  req_sign_ext;
    logic [2:0]  resp_ready;
    logic [1:0]  req_size  [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    wire  [2:0]  req_ready;
    wire  [2:0]  resp_valid;
    wire  [2:0]  resp_err;
    wire  [31:0] resp_rdata [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [3][1024];

    typedef struct {
        int          inst;
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(10), .LATENCY(1), .BIG_ENDIAN(1'b0)) u_dut_le (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_sign_ext(req_sign_ext[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_ctrl #(.ADDR_W(10), .LATENCY(4), .BIG_ENDIAN(1'b1)) u_dut_be (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_sign_ext(req_sign_ext[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_ctrl #(.ADDR_W(10), .LATENCY(0), .BIG_ENDIAN(1'b0)) u_dut_z (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_size(req_size[2]), .req_sign_ext(req_sign_ext[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
        .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    function automatic int lat_of(input int inst);
        case (inst)
            0:       return 1;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Byte-array reference: applies stores, and returns what a load/request should respond with.
    task automatic model_access(input int inst, input logic we, input logic [1:0] size, input logic sign,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] exp_rdata, output logic exp_err);
        int     n;
        int     pos;
        longint value;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_err   = (size == 2'd3) || (addr >= 32'd1024) || ((addr % n) != 0);
        exp_rdata = 32'd0;
        if (exp_err)
            return;
        if (we) begin
            value = longint'(wdata);
            for (int k = 0; k < n; k++) begin
                pos = (inst == 1) ? n - 1 - k : k;
                model_mem[inst][int'(addr) + k] = 8'((value >> (8 * pos)) & 255);
            end
        end else begin
            value = 0;
            for (int k = 0; k < n; k++) begin
                if (inst == 1)
                    value = value * 256 + longint'(model_mem[inst][int'(addr) + k]);
                else
                    value = value + (longint'(model_mem[inst][int'(addr) + k]) << (8 * k));
            end
            if (sign && n < 4 && value >= (longint'(1) << (8 * n - 1)))
                value = value - (longint'(1) << (8 * n));
            exp_rdata = value[31:0];
        end
    endtask

    task automatic setReq(input int inst, input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata);
        req_we[inst]       = we;
        req_size[inst]     = size;
        req_sign_ext[inst] = sign;
        req_addr[inst]     = addr;
        req_wdata[inst]    = wdata;
    endtask

    // One complete transaction with latency, stability and handshake checks against the model.
    task automatic applyStimulus(input int inst, input logic we, input logic [1:0] size, input logic sign,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                                 input string name, output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          cycles;
        model_access(inst, we, size, sign, addr, wdata, exp_rdata, exp_err);
        @(negedge clk);
        setReq(inst, we, size, sign, addr, wdata);
        req_valid[inst]  = 1'b1;
        resp_ready[inst] = 1'b0;
        cycles = 0;
        while (!req_ready[inst] && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput($sformatf("%s accept", name), 32'(req_ready[inst]), 32'd1);
        if (!req_ready[inst]) begin
            req_valid[inst] = 1'b0;
            got_rdata = 32'd0;
            got_err   = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[inst] = 1'b0;
        cycles = 1;
        while (!resp_valid[inst] && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput($sformatf("%s latency", name), 32'(cycles), 32'(exp_err ? 1 : 1 + lat_of(inst)));
        checkOutput($sformatf("%s rdata", name), resp_rdata[inst], exp_rdata);
        checkOutput($sformatf("%s err", name), 32'(resp_err[inst]), 32'(exp_err));
        checkOutput($sformatf("%s ready low", name), 32'(req_ready[inst]), 32'd0);
        got_rdata = resp_rdata[inst];
        got_err   = resp_err[inst];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput($sformatf("%s hold valid", name), 32'(resp_valid[inst]), 32'd1);
            checkOutput($sformatf("%s hold rdata", name), resp_rdata[inst], exp_rdata);
        end
        resp_ready[inst] = 1'b1;
        @(negedge clk);
        resp_ready[inst] = 1'b0;
        checkOutput($sformatf("%s resp done", name), 32'(resp_valid[inst]), 32'd0);
        checkOutput($sformatf("%s idle ready", name), 32'(req_ready[inst]), 32'd1);
    endtask

    function automatic void add_vec(input int inst, input logic we, input logic [1:0] size, input logic sign,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.inst = inst; v.we = we; v.size = size; v.sign = sign;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] got_rdata;
        logic        got_err;
        logic [31:0] r_addr;
        int          cycles;

        // inst 0: LE lat1, inst 1: BE lat4, inst 2: LE lat0
        add_vec(0, 1, 2, 0, 32'h10,  32'h8899AABC, 32'h0,        0);
        add_vec(0, 0, 0, 1, 32'h10,  32'h0,        32'hFFFFFFBC, 0);
        add_vec(0, 0, 1, 0, 32'h12,  32'h0,        32'h00008899, 0);
        add_vec(0, 0, 1, 1, 32'h12,  32'h0,        32'hFFFF8899, 0);
        add_vec(0, 0, 0, 0, 32'h13,  32'h0,        32'h00000088, 0);
        add_vec(0, 0, 2, 1, 32'h10,  32'h0,        32'h8899AABC, 0);
        add_vec(0, 1, 2, 0, 32'h0,   32'h01020304, 32'h0,        0);
        add_vec(0, 1, 2, 0, 32'h400, 32'hDEADBEEF, 32'h0,        1);
        add_vec(0, 0, 2, 0, 32'h0,   32'h0,        32'h01020304, 0);
        add_vec(0, 0, 0, 1, 32'h3,   32'h0,        32'h00000001, 0);
        add_vec(1, 1, 2, 0, 32'h20,  32'h11223344, 32'h0,        0);
        add_vec(1, 0, 0, 0, 32'h20,  32'h0,        32'h00000011, 0);
        add_vec(1, 0, 2, 0, 32'h20,  32'h0,        32'h11223344, 0);
        add_vec(1, 0, 2, 0, 32'h22,  32'h0,        32'h0,        1);
        add_vec(1, 0, 3, 0, 32'h20,  32'h0,        32'h0,        1);
        add_vec(1, 0, 2, 0, 32'h20,  32'h0,        32'h11223344, 0);
        add_vec(1, 0, 1, 1, 32'h22,  32'h0,        32'h00003344, 0);
        add_vec(1, 1, 0, 0, 32'h21,  32'hFFFFFFA5, 32'h0,        0);
        add_vec(1, 0, 2, 0, 32'h20,  32'h0,        32'h11A53344, 0);
        add_vec(1, 0, 1, 1, 32'h20,  32'h0,        32'h000011A5, 0);
        add_vec(1, 0, 0, 1, 32'h21,  32'h0,        32'hFFFFFFA5, 0);
        add_vec(1, 1, 2, 0, 32'h30,  32'h0,        32'h0,        0);
        add_vec(2, 1, 1, 0, 32'h3FE, 32'h0000BEEF, 32'h0,        0);
        add_vec(2, 0, 1, 1, 32'h3FE, 32'h0,        32'hFFFFBEEF, 0);
        add_vec(2, 0, 0, 0, 32'h3FF, 32'h0,        32'h000000BE, 0);
        add_vec(2, 0, 1, 0, 32'h3FF, 32'h0,        32'h0,        1);
        add_vec(2, 1, 2, 0, 32'h3FE, 32'h12345678, 32'h0,        1);
        add_vec(2, 0, 1, 0, 32'h3FE, 32'h0,        32'h0000BEEF, 0);
        add_vec(2, 0, 2, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1);
        add_vec(2, 1, 0, 0, 32'h200, 32'h00000077, 32'h0,        0);
        add_vec(2, 0, 0, 1, 32'h200, 32'h0,        32'h00000077, 0);

        rst_n      = 3'b000;
        req_valid  = 3'b000;
        resp_ready = 3'b000;
        for (int i = 0; i < 3; i++) setReq(i, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset ready[%0d]", i), 32'(req_ready[i]), 32'd0);
            checkOutput($sformatf("reset valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
            checkOutput($sformatf("reset rdata[%0d]", i), resp_rdata[i], 32'd0);
            checkOutput($sformatf("reset err[%0d]", i), 32'(resp_err[i]), 32'd0);
        end
        rst_n = 3'b111;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("post-reset ready[%0d]", i), 32'(req_ready[i]), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].inst, vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr,
                          vecs[i].wdata, i % 3, $sformatf("vec%0d", i), got_rdata, got_err);
            checkOutput($sformatf("vec%0d table rdata", i), got_rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d table err", i), 32'(got_err), 32'(vecs[i].exp_err));
        end

        // Backpressure on inst 0: next request waits until the response handshake.
        @(negedge clk);
        setReq(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        req_valid[0] = 1'b1;
        checkOutput("bp accept ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checkOutput("bp wait no resp", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        checkOutput("bp resp valid", 32'(resp_valid[0]), 32'd1);
        checkOutput("bp rdata", resp_rdata[0], 32'h8899AABC);
        setReq(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        req_valid[0] = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            checkOutput("bp hold valid", 32'(resp_valid[0]), 32'd1);
            checkOutput("bp hold rdata", resp_rdata[0], 32'h8899AABC);
            checkOutput("bp hold ready", 32'(req_ready[0]), 32'd0);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        resp_ready[0] = 1'b0;
        checkOutput("bp released valid", 32'(resp_valid[0]), 32'd0);
        checkOutput("bp released ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checkOutput("bp second accepted", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        checkOutput("bp second valid", 32'(resp_valid[0]), 32'd1);
        checkOutput("bp second rdata", resp_rdata[0], 32'h000000AA);
        resp_ready[0] = 1'b1;
        @(negedge clk);
        resp_ready[0] = 1'b0;
        checkOutput("bp second done", 32'(resp_valid[0]), 32'd0);

        // Reset while a load response is pending clears the outputs asynchronously.
        setReq(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        cycles = 1;
        while (!resp_valid[1] && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("rstresp latency", 32'(cycles), 32'd5);
        checkOutput("rstresp rdata", resp_rdata[1], 32'h11A53344);
        #1 rst_n[1] = 1'b0;
        #1;
        checkOutput("rstresp valid", 32'(resp_valid[1]), 32'd0);
        checkOutput("rstresp rdata clr", resp_rdata[1], 32'd0);
        checkOutput("rstresp err clr", 32'(resp_err[1]), 32'd0);
        checkOutput("rstresp ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        checkOutput("rstresp ready after", 32'(req_ready[1]), 32'd1);
        checkOutput("rstresp valid after", 32'(resp_valid[1]), 32'd0);

        // Reset during WAIT of a store: the store must never land.
        setReq(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);
        req_valid[1] = 1'b1;
        checkOutput("rstwait accept", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        checkOutput("rstwait in wait", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        #1 rst_n[1] = 1'b0;
        #1;
        checkOutput("rstwait valid", 32'(resp_valid[1]), 32'd0);
        checkOutput("rstwait ready", 32'(req_ready[1]), 32'd0);
        for (int h = 0; h < 6; h++) begin
            @(negedge clk);
            checkOutput("rstwait no resp", 32'(resp_valid[1]), 32'd0);
        end
        rst_n[1] = 1'b1;
        @(negedge clk);
        checkOutput("rstwait ready after", 32'(req_ready[1]), 32'd1);
        checkOutput("rstwait no late resp", 32'(resp_valid[1]), 32'd0);
        applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, "rstwait reload", got_rdata, got_err);
        checkOutput("rstwait store dropped", got_rdata, 32'h0);

        // Random traffic over an initialised window plus occasional illegal requests.
        for (int inst = 0; inst < 3; inst++) begin
            for (int w = 0; w < 16; w++)
                applyStimulus(inst, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(w * 4), $urandom, 0,
                              $sformatf("init%0d_%0d", inst, w), got_rdata, got_err);
            for (int t = 0; t < 50; t++) begin
                case ($urandom % 8)
                    0:       r_addr = 32'h400 + ($urandom % 256);
                    1:       r_addr = $urandom | 32'h8000_0000;
                    default: r_addr = 32'h100 + ($urandom % 64);
                endcase
                applyStimulus(inst, 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), r_addr,
                              $urandom, int'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", inst, t),
                              got_rdata, got_err);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
